// File: rtl/puf_sched_pkg.sv
// Shared types and widths for the PUF request scheduler.
package puf_sched_pkg;

  localparam int CHAL_W = 16;
  localparam int RESP_W = 128;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/puf_rr_arb.sv
// Round-robin arbiter: the first set request at or after ptr_i (wrapping) wins.
module puf_rr_arb
  import puf_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // i is the search distance from the pointer, j the requester it lands on
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any_o && (j == (int'(ptr_i) + i) % NREQ) && req_i[j]) begin
          any_o    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/puf_req_scheduler.sv
// Schedules NREQ requesters onto one shared 128-bit PUF engine, round-robin, one run at a time.
// Define PUF_SCHED_WATCHDOG_EN to abort stuck engine runs after TIMEOUT_CYC WAIT cycles.
module puf_req_scheduler
  import puf_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [CHAL_W*NREQ-1:0] chal,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [RESP_W-1:0]      resp_data,
  output logic                   resp_err,
  output logic                   eng_rst,
  output logic [CHAL_W-1:0]      eng_C,
  input  logic                   eng_done,
  input  logic [RESP_W-1:0]      eng_out,
  output state_e                 dbg_state
);

  // Response handshake: resp_valid stays high with resp_id/resp_data/resp_err frozen
  // until a cycle where resp_ready is also high; that cycle is the transfer.
  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d, next_ptr, arb_idx;
  logic [CHAL_W-1:0] chal_q, chal_d, chal_sel;
  logic [RESP_W-1:0] data_q, data_d;
  logic              load_q, load_d, drop_q, drop_d;
  logic [NREQ-1:0]   id_vec, arb_gnt;
  logic              arb_any, served_req, timeout;

  puf_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    chal_sel = '0;
    id_vec   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_gnt[j]) chal_sel = chal[j*CHAL_W +: CHAL_W];
      id_vec[j] = (j == int'(id_q));
    end
  end

  assign served_req = |(req & id_vec);
  assign next_ptr   = (int'(id_q) == NREQ - 1) ? '0 : id_q + ID_W'(1);

`ifdef PUF_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q;
  logic            err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wdog_q <= '0;
    else if (state_q != S_WAIT) wdog_q <= '0;
    else                        wdog_q <= wdog_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign timeout  = (state_q == S_WAIT) && (wdog_q == WD_W'(TIMEOUT_CYC - 1));
  assign resp_err = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
  assign timeout            = 1'b0;
  assign resp_err           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    chal_d  = chal_q;
    data_d  = data_q;
    load_d  = load_q;
    drop_d  = drop_q;
`ifdef PUF_SCHED_WATCHDOG_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          state_d = S_LOAD;
          id_d    = arb_idx;
          chal_d  = chal_sel;
          load_d  = 1'b0;
          drop_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (!served_req) drop_d = 1'b1;
        if (load_q) state_d = S_WAIT;
        else        load_d  = 1'b1;
      end
      S_WAIT: begin
        if (!served_req) drop_d = 1'b1;
        // An abandoned run still completes so the engine is not cut mid-evaluation
        if (eng_done || timeout) begin
          if (drop_q || !served_req) begin
            state_d = S_IDLE;
            ptr_d   = next_ptr;
          end else begin
            state_d = S_RESP;
            data_d  = eng_done ? eng_out : '0;
`ifdef PUF_SCHED_WATCHDOG_EN
            err_d   = !eng_done;
`endif
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      chal_q  <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      chal_q  <= chal_d;
      data_q  <= data_d;
      load_q  <= load_d;
      drop_q  <= drop_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign gnt        = busy ? id_vec : '0;
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign eng_rst    = (state_q != S_WAIT);
  assign eng_C      = chal_q;
  assign dbg_state  = state_q;

endmodule
